// File: rtl/diff_pair_sched_if.sv
// rtl/diff_pair_sched_if.sv - requester/response bundle for diff_pair_sched
interface diff_pair_sched_if #(
   parameter int WIDTH = 6
);
   logic             req_0;
   logic             req_1;
   logic [WIDTH-1:0] a_0;
   logic [WIDTH-1:0] b_0;
   logic [WIDTH-1:0] a_1;
   logic [WIDTH-1:0] b_1;
   logic             ack_0;
   logic             ack_1;
   logic             valid_out;
   logic [WIDTH-1:0] out1;
   logic             grant_id;
   logic             busy;

   modport master (
      output req_0, req_1, a_0, b_0, a_1, b_1,
      input  ack_0, ack_1, valid_out, out1, grant_id, busy
   );

   modport slave (
      input  req_0, req_1, a_0, b_0, a_1, b_1,
      output ack_0, ack_1, valid_out, out1, grant_id, busy
   );
endinterface

// File: rtl/diff_pair_sched.sv
// rtl/diff_pair_sched.sv - round-robin scheduler for the shared reg_1 - reg_0 datapath
module diff_pair_sched #(
   parameter int WIDTH = 6
) (
   input  logic               clock_0,
   input  logic               reset_0,
   diff_pair_sched_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t           state;
   logic             rr;
   logic [WIDTH-1:0] reg_0;
   logic [WIDTH-1:0] reg_1;
   logic             grant_next;

   always_comb begin
      grant_next = bus.req_1;
      if (bus.req_0 && bus.req_1) begin
         grant_next = rr;
      end
   end

   // RESP spans two cycles: the first raises valid/ack, the second retires them.
   always_ff @(posedge clock_0) begin
      if (!reset_0) begin
         state         <= IDLE;
         rr            <= 1'b0;
         reg_0         <= '0;
         reg_1         <= '0;
         bus.out1      <= '0;
         bus.valid_out <= 1'b0;
         bus.ack_0     <= 1'b0;
         bus.ack_1     <= 1'b0;
         bus.grant_id  <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_0 || bus.req_1) begin
                  reg_0        <= grant_next ? bus.a_1 : bus.a_0;
                  reg_1        <= grant_next ? bus.b_1 : bus.b_0;
                  bus.grant_id <= grant_next;
                  bus.busy     <= 1'b1;
                  state        <= CALC;
               end
            end
            CALC: begin
               bus.out1 <= reg_1 - reg_0;
               state    <= RESP;
            end
            RESP: begin
               if (!bus.valid_out) begin
                  bus.valid_out <= 1'b1;
                  bus.ack_0     <= ~bus.grant_id;
                  bus.ack_1     <= bus.grant_id;
               end else begin
                  bus.valid_out <= 1'b0;
                  bus.ack_0     <= 1'b0;
                  bus.ack_1     <= 1'b0;
                  bus.busy      <= 1'b0;
                  rr            <= ~bus.grant_id;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_diff_pair_sched.sv
// tb/tb_diff_pair_sched.sv - self-checking bench for diff_pair_sched
module tb_diff_pair_sched;
   localparam int WIDTH = 6;

   logic clock_0 = 1'b0;
   logic reset_0 = 1'b0;

   diff_pair_sched_if #(.WIDTH(WIDTH)) bus ();

   diff_pair_sched #(.WIDTH(WIDTH)) dut (
      .clock_0 (clock_0),
      .reset_0 (reset_0),
      .bus     (bus)
   );

   always #5 clock_0 = ~clock_0;

   int checks = 0;
   int errors = 0;

   // Transaction-timeline model: a grant at edge g yields out1 at g+1,
   // the valid/ack pulse after g+2, and a return to idle at g+3.
   int         e = 0;
   bit         m_active = 1'b0;
   int         m_gnt = 0;
   bit         m_g = 1'b0;
   bit         m_rr = 1'b0;
   int         m_res = 0;
   int         m_out1 = 0;
   bit         m_gid = 1'b0;
   bit         hold = 1'b0;
   bit         rnd = 1'b0;
   int         gnt_log[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic set_req(input int r, input logic v);
      if (r == 0) bus.req_0 = v;
      else        bus.req_1 = v;
   endtask

   task automatic set_ops(input int r, input int a, input int b);
      if (r == 0) begin
         bus.a_0 = WIDTH'(a);
         bus.b_0 = WIDTH'(b);
      end else begin
         bus.a_1 = WIDTH'(a);
         bus.b_1 = WIDTH'(b);
      end
   endtask

   task automatic model_edge();
      e++;
      if (!reset_0) begin
         m_active = 1'b0;
         m_rr     = 1'b0;
         m_out1   = 0;
         m_gid    = 1'b0;
      end else if (m_active) begin
         if (e == m_gnt + 1) m_out1 = m_res;
         if (e == m_gnt + 3) begin
            m_active = 1'b0;
            m_rr     = ~m_g;
         end
      end else if (bus.req_0 || bus.req_1) begin
         m_g      = (bus.req_0 && bus.req_1) ? m_rr : bus.req_1;
         m_res    = m_g ? (int'(bus.b_1) - int'(bus.a_1) + 64) % 64
                        : (int'(bus.b_0) - int'(bus.a_0) + 64) % 64;
         m_active = 1'b1;
         m_gnt    = e;
         m_gid    = m_g;
         gnt_log.push_back(int'(m_g));
      end
   endtask

   task automatic step();
      logic exp_v;
      @(posedge clock_0);
      model_edge();
      #1;
      exp_v = m_active && (e == m_gnt + 2);
      check("busy",      bus.busy,      m_active);
      check("valid_out", bus.valid_out, exp_v);
      check("ack_0",     bus.ack_0,     exp_v && !m_g);
      check("ack_1",     bus.ack_1,     exp_v && m_g);
      check("out1",      bus.out1,      m_out1);
      check("grant_id",  bus.grant_id,  m_gid);
      if (exp_v && !hold) set_req(int'(m_g), 1'b0);
      if (rnd && m_active && $urandom_range(7) == 0) set_req(int'(m_g), 1'b0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      bus.req_0 = 1'b0;
      bus.req_1 = 1'b0;
      set_ops(0, 0, 0);
      set_ops(1, 0, 0);

      // reset then single request 3 - 1
      reset_0 = 1'b0;
      run(2);
      check("rst_out1", bus.out1, 0);
      check("rst_busy", bus.busy, 0);
      reset_0 = 1'b1;
      run(1);
      set_ops(0, 1, 3);
      set_req(0, 1'b1);
      step();
      step();
      check("single_out1", bus.out1, 2);
      step();
      check("single_ack0", bus.ack_0, 1);
      check("single_ack1", bus.ack_1, 0);
      step();

      // wrap-around and equal operands
      set_ops(1, 2, 1);
      set_req(1, 1'b1);
      run(4);
      check("wrap_out1", bus.out1, 63);
      set_ops(1, 5, 5);
      set_req(1, 1'b1);
      run(4);
      check("zero_out1", bus.out1, 0);

      // contention with both requests held
      reset_0 = 1'b0;
      step();
      reset_0 = 1'b1;
      gnt_log.delete();
      hold = 1'b1;
      set_ops(0, 4, 10);
      set_ops(1, 9, 3);
      set_req(0, 1'b1);
      set_req(1, 1'b1);
      run(16);
      check("cont_count", gnt_log.size(), 4);
      foreach (gnt_log[i]) check("cont_order", gnt_log[i], i % 2);
      hold = 1'b0;
      set_req(0, 1'b0);
      set_req(1, 1'b0);
      run(4);

      // operands change and req drops right after the grant
      set_ops(0, 1, 9);
      set_req(0, 1'b1);
      step();
      set_ops(0, 7, 9);
      set_req(0, 1'b0);
      step();
      step();
      check("stab_ack0", bus.ack_0, 1);
      check("stab_out1", bus.out1, 8);
      step();

      // reset during CALC
      set_ops(1, 0, 4);
      set_req(1, 1'b1);
      step();
      reset_0 = 1'b0;
      set_req(1, 1'b0);
      step();
      check("midrst_out1", bus.out1, 0);
      check("midrst_busy", bus.busy, 0);
      reset_0 = 1'b1;
      run(4);

      // idle hold after a result of 2
      set_ops(0, 1, 3);
      set_req(0, 1'b1);
      run(4);
      run(10);
      check("hold_out1", bus.out1, 2);

      // randomized traffic
      rnd = 1'b1;
      for (int c = 0; c < 600; c++) begin
         for (int r = 0; r < 2; r++) begin
            logic cur;
            cur = (r == 0) ? bus.req_0 : bus.req_1;
            if ($urandom_range(3) == 0) begin
               set_ops(r, int'($urandom_range(63)), int'($urandom_range(63)));
               if (!cur) set_req(r, 1'b1);
            end
         end
         if ($urandom_range(99) == 0) reset_0 = 1'b0;
         else                         reset_0 = 1'b1;
         step();
      end
      rnd = 1'b0;
      reset_0 = 1'b1;
      set_req(0, 1'b0);
      set_req(1, 1'b0);
      run(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/diff_pair_sched.md
# diff_pair_sched

Sequencing and arbitration controller for the shared 6-bit register-pair difference datapath (operand registers reg_0/reg_1, result = reg_1 − reg_0). Two requesters each present an operand pair. The block grants the shared datapath to one requester at a time with round-robin fairness, then loads the operand registers and computes the modular difference. It returns the result through a one-cycle valid/ack response. It sits between the requester-side control logic and the difference unit, and is the only writer of the operand registers.

## Interface
Parameters:
- WIDTH, 6, operand and result width in bits.

Ports:
- clock_0  input  1  single clock; all state updates on its rising edge.
- reset_0  input  1  reset, synchronous, active-low; sampled on rising clock_0.
- req_0  input  1  requester 0 request, level; held until ack_0.
- req_1  input  1  requester 1 request, level; held until ack_1.
- a_0, b_0  input  WIDTH  requester 0 operands; result = b_0 − a_0.
- a_1, b_1  input  WIDTH  requester 1 operands; result = b_1 − a_1.
- ack_0, ack_1  output  1  one-cycle completion pulse to the granted requester.
- valid_out  output  1  one-cycle pulse; out1 holds a new result.
- out1  output  WIDTH  registered difference result.
- grant_id  output  1  index of the current or last granted requester.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester named by the round-robin pointer rr. rr = 0 after reset.
  - On the granting edge: reg_0 <= a_g, reg_1 <= b_g, grant_id <= g, state -> CALC.
- CALC: out1 <= (reg_1 − reg_0) mod 2^WIDTH; state -> RESP. There is no sign or borrow output.
- RESP:
  - valid_out = 1, and ack_g = 1 for the granted requester only.
  - On the next edge: state -> IDLE and rr <= ~g, so the other requester has priority next time.
- Operands are sampled only on the granting edge. Changes to a/b or to req after that edge do not affect the result.
- A request that drops during CALC or RESP does not abort the transaction. The ack is still issued.
- A requester must deassert req by the edge that ends RESP. If req is still high in IDLE, it is treated as a new request.
- out1 and grant_id hold their values until the next CALC edge or grant edge, respectively.
- Reset values, at the first edge with reset_0 = 0:
  - state = IDLE, rr = 0, reg_0 = reg_1 = 0.
  - out1 = 0, valid_out = 0, ack_0 = ack_1 = 0, grant_id = 0, busy = 0.
- Reset asserted mid-transaction (in CALC or RESP) abandons the transaction. No ack is issued, and out1 is cleared to 0.

## Timing
- Request sampled at edge N. Edge N is the grant edge and sets busy = 1.
- out1 is updated at edge N+1.
- valid_out and ack are high from edge N+2 to edge N+3.
- From edge N+3 the block is in IDLE. The earliest next grant is edge N+4.
- Peak throughput: one result per 4 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- valid_out and ack_g are asserted together and are never high for more than one cycle.
- busy is high from the grant edge until the edge that ends RESP.

## Test plan
- Reset, then single request: req_0 = 1, a_0 = 1, b_0 = 3 at edge N -> out1 = 2 after edge N+1; valid_out = ack_0 = 1 for exactly cycle N+2; ack_1 stays 0; grant_id = 0.
- Wrap-around: req_1 = 1, a_1 = 2, b_1 = 1 -> out1 = 63 (6'h3F); a_1 = b_1 = 5 -> out1 = 0.
- Contention: req_0 = req_1 = 1 held continuously after reset -> grants alternate 0, 1, 0, 1. Each ack arrives 4 cycles apart and is a one-cycle pulse.
- Operand stability: change a_0 from 1 to 7 and drop req_0 in the cycle after the grant -> result still uses a_0 = 1, and ack_0 is still issued.
- Reset mid-operation: assert reset_0 = 0 during CALC -> next cycle state = IDLE, out1 = 0, busy = 0, and no valid_out or ack pulse appears.
- Idle hold: no requests for 10 cycles after a result of 2 -> out1 stays 2, and busy, valid_out and both acks stay 0.
